// File: rtl/seven_seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_ctrl_if
//  Description : Bundle between the digit source (switch/count logic) and
//                the seven-segment scan controller.
//                  en          display enable (low blanks both anodes)
//                  digit0      hex value for digit 0 (right)
//                  digit1      hex value for digit 1 (left)
//                  s           hex code to the shared decoder
//                  an          active-low anode enables, an[0] = digit 0
//                  frame_tick  one-cycle pulse on the first cycle of a frame
//                master : the digit source side
//                slave  : the scan controller side
//  Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_ctrl_if;
  logic       en;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] s;
  logic [1:0] an;
  logic       frame_tick;

  modport master (
    output en,
    output digit0,
    output digit1,
    input  s,
    input  an,
    input  frame_tick
  );

  modport slave (
    input  en,
    input  digit0,
    input  digit1,
    output s,
    output an,
    output frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_ctrl
//  Description : Time-multiplexed scan controller for two common-anode
//                seven-segment digits sharing one hex decoder. Cycles
//                SHOW0 -> BLANK0 -> SHOW1 -> BLANK1, blanking both anodes
//                between digits to prevent ghosting. Both digit values are
//                captured together at the start of each frame so a
//                displayed pair never tears.
//  Ports       : clk      system clock, rising edge
//                reset_n  asynchronous active-low reset
//                bus      seven_seg_scan_ctrl_if.slave
//                           en, digit0, digit1 in; s, an, frame_tick out
//  Parameters  : DWELL_CYCLES  cycles each digit is lit per frame (>= 1)
//                BLANK_CYCLES  cycles of blanking between digits (0 = none)
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl #(
  parameter int DWELL_CYCLES = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  seven_seg_scan_ctrl_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int MAX_LEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                         : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  // Unused when blanking is disabled; tied to zero to stay well defined.
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1)
                                                            : {CW{1'b0}};

  localparam logic [1:0] SHOW0  = 2'd0;
  localparam logic [1:0] BLANK0 = 2'd1;
  localparam logic [1:0] SHOW1  = 2'd2;
  localparam logic [1:0] BLANK1 = 2'd3;

  // Reset parks the FSM in the phase just before SHOW0 so the first frame
  // starts after one full blank (or dwell, without blanking) interval.
  localparam logic [1:0] RESET_STATE = (BLANK_CYCLES > 0) ? BLANK1 : SHOW1;

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_DIG0 = 2'b10;
  localparam logic [1:0] AN_DIG1 = 2'b01;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_lat1;
  // r_s doubles as the digit-0 latch: it is loaded with digit0 on entry to
  // SHOW0 and holds until SHOW1, so no separate lat0 register is needed.
  logic [3:0]    r_s;
  // Anode pattern the phase calls for, ignoring en. Kept separately so that
  // re-asserting en restores the right pattern mid-phase.
  logic [1:0]    r_pattern;
  logic [1:0]    r_an;
  logic          r_frame_tick;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic          w_is_show;
  logic          w_phase_last;
  logic [1:0]    w_next_state;
  logic [1:0]    w_state_d;
  logic [CW-1:0] w_cnt_d;
  logic          w_enter_show0;
  logic          w_enter_show1;
  logic [1:0]    w_pattern_d;
  logic [1:0]    w_an_d;
  logic [3:0]    w_s_d;

  assign w_is_show    = (r_state == SHOW0) || (r_state == SHOW1);
  assign w_phase_last = w_is_show ? (r_cnt == DWELL_LAST)
                                  : (r_cnt == BLANK_LAST);

  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      always_comb begin
        w_next_state = SHOW0;
        case (r_state)
          SHOW0:   w_next_state = BLANK0;
          BLANK0:  w_next_state = SHOW1;
          SHOW1:   w_next_state = BLANK1;
          default: w_next_state = SHOW0;
        endcase
      end
    end else begin : g_no_blank
      // BLANK states are unreachable; ping-pong between the two SHOW states.
      always_comb begin
        w_next_state = SHOW0;
        case (r_state)
          SHOW0:   w_next_state = SHOW1;
          default: w_next_state = SHOW0;
        endcase
      end
    end
  endgenerate

  assign w_state_d     = w_phase_last ? w_next_state : r_state;
  assign w_cnt_d       = w_phase_last ? {CW{1'b0}} : (r_cnt + 1'b1);
  assign w_enter_show0 = w_phase_last && (w_next_state == SHOW0);
  assign w_enter_show1 = w_phase_last && (w_next_state == SHOW1);

  // Output next values. Everything changes on the transition edge only,
  // except an, which additionally follows en with one cycle of latency.
  always_comb begin
    w_pattern_d = r_pattern;
    w_s_d       = r_s;
    if (w_enter_show0) begin
      w_pattern_d = AN_DIG0;
      w_s_d       = bus.digit0;
    end else if (w_enter_show1) begin
      w_pattern_d = AN_DIG1;
      w_s_d       = r_lat1;
    end else if (w_phase_last) begin
      w_pattern_d = AN_OFF;
    end
  end

  // Only 10, 01 or 11 can ever be produced, so both anodes are never low.
  assign w_an_d = bus.en ? w_pattern_d : AN_OFF;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= RESET_STATE;
      r_cnt        <= {CW{1'b0}};
      r_lat1       <= 4'h0;
      r_s          <= 4'h0;
      r_pattern    <= AN_OFF;
      r_an         <= AN_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_s          <= w_s_d;
      r_pattern    <= w_pattern_d;
      r_an         <= w_an_d;
      r_frame_tick <= w_enter_show0;
      // Digit 1 is captured together with digit 0 so the pair never tears.
      if (w_enter_show0) begin
        r_lat1 <= bus.digit1;
      end
    end
  end

  assign bus.s          = r_s;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_ctrl
//  Description : Scoreboard bench for seven_seg_scan_ctrl. Instance A uses
//                DWELL=4/BLANK=2, instance B uses DWELL=3/BLANK=0. Stimulus
//                pushes hand-computed expected outputs into per-instance
//                queues; monitors pop and compare on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

  typedef struct packed {
    logic [1:0] an;
    logic [3:0] s;
    logic       ft;
  } exp_t;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;
  logic rnd_on;

  int n_checks;
  int n_pass;

  exp_t q_a[$];
  exp_t q_b[$];

  seven_seg_scan_ctrl_if bus_a ();
  seven_seg_scan_ctrl_if bus_b ();

  seven_seg_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .bus     (bus_a.slave)
  );

  seven_seg_scan_ctrl #(.DWELL_CYCLES(3), .BLANK_CYCLES(0)) dut_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .bus     (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a_an", int'(bus_a.an), int'(e.an));
      check("a_s", int'(bus_a.s), int'(e.s));
      check("a_frame_tick", int'(bus_a.frame_tick), int'(e.ft));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b_an", int'(bus_b.an), int'(e.an));
      check("b_s", int'(bus_b.s), int'(e.s));
      check("b_frame_tick", int'(bus_b.frame_tick), int'(e.ft));
    end
  end

  // Invariants during the random phase.
  logic prev_ft_a, prev_ft_b, seen_ft_a;
  int   since_ft_a;
  initial begin
    prev_ft_a = 1'b0; prev_ft_b = 1'b0; seen_ft_a = 1'b0; since_ft_a = 0;
  end
  always @(negedge clk) begin
    if (rnd_on) begin
      check("a_an_not_00", int'(bus_a.an == 2'b00), 0);
      check("b_an_not_00", int'(bus_b.an == 2'b00), 0);
      check("a_ft_double", int'(bus_a.frame_tick && prev_ft_a), 0);
      check("b_ft_double", int'(bus_b.frame_tick && prev_ft_b), 0);
      if (bus_a.frame_tick && seen_ft_a) check("a_ft_spacing", since_ft_a, 12);
    end
    if (bus_a.frame_tick) begin
      since_ft_a = 1;
      seen_ft_a  = 1'b1;
    end else begin
      since_ft_a++;
    end
    prev_ft_a = bus_a.frame_tick;
    prev_ft_b = bus_b.frame_tick;
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step_a(input logic [1:0] an, input logic [3:0] s, input logic ft);
    @(posedge clk); #1;
    q_a.push_back(exp_t'{an: an, s: s, ft: ft});
  endtask

  task automatic step_b(input logic [1:0] an, input logic [3:0] s, input logic ft);
    @(posedge clk); #1;
    q_b.push_back(exp_t'{an: an, s: s, ft: ft});
  endtask

  // Instance A: two cycles in reset, release, then edge 1 still blank.
  task automatic reset_hold_a();
    repeat (2) step_a(2'b11, 4'h0, 1'b0);
    rst_a_n = 1'b1;
    step_a(2'b11, 4'h0, 1'b0);
  endtask

  // One frame of instance A starting at the SHOW0 entry edge. en_low[k]
  // means en is sampled low at frame edge k. Optional digit changes are
  // applied right after edge d0_at / d1_at.
  task automatic frame_a(input logic [3:0] s0, input logic [3:0] s1,
                         input logic [12:1] en_low,
                         input logic [3:0] nd0, input int d0_at,
                         input logic [3:0] nd1, input int d1_at,
                         input int n_steps);
    for (int k = 1; k <= n_steps; k++) begin
      logic [1:0] base;
      logic [3:0] sv;
      if (k <= 4)       begin base = 2'b10; sv = s0; end
      else if (k <= 6)  begin base = 2'b11; sv = s0; end
      else if (k <= 10) begin base = 2'b01; sv = s1; end
      else              begin base = 2'b11; sv = s1; end
      step_a(en_low[k] ? 2'b11 : base, sv, (k == 1));
      if (k == d0_at) bus_a.digit0 = nd0;
      if (k == d1_at) bus_a.digit1 = nd1;
      bus_a.en = (k < 12) ? !en_low[k+1] : 1'b1;
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; rnd_on = 1'b0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    bus_a.en = 1'b1; bus_a.digit0 = 4'h3; bus_a.digit1 = 4'hA;
    bus_b.en = 1'b1; bus_b.digit0 = 4'h5; bus_b.digit1 = 4'hC;

    // Startup and steady frames.
    reset_hold_a();
    frame_a(4'h3, 4'hA, 12'h000, 4'h0, 0, 4'h0, 0, 12);
    // Digit changes mid-SHOW0 / mid-BLANK0 appear only in the next frame.
    frame_a(4'h3, 4'hA, 12'h000, 4'hF, 2, 4'h7, 5, 12);
    frame_a(4'hF, 4'h7, 12'h000, 4'h0, 0, 4'h0, 0, 12);
    // en low at edges 10..12 spanning SHOW1 -> BLANK1.
    frame_a(4'hF, 4'h7, 12'hE00, 4'h0, 0, 4'h0, 0, 12);
    // en low for one edge mid-SHOW0, restored mid-phase.
    frame_a(4'hF, 4'h7, 12'h002, 4'h0, 0, 4'h0, 0, 12);
    // Asynchronous reset mid-SHOW1, checked before the next clock edge.
    frame_a(4'hF, 4'h7, 12'h000, 4'h0, 0, 4'h0, 0, 7);
    bus_a.digit0 = 4'h3; bus_a.digit1 = 4'hA;
    @(posedge clk); #1;
    rst_a_n = 1'b0;
    #1;
    q_a.push_back(exp_t'{an: 2'b11, s: 4'h0, ft: 1'b0});
    reset_hold_a();
    frame_a(4'h3, 4'hA, 12'h000, 4'h0, 0, 4'h0, 0, 12);
    frame_a(4'h3, 4'hA, 12'h000, 4'h0, 0, 4'h0, 0, 12);

    // Instance B: no blanking.
    step_b(2'b11, 4'h0, 1'b0);
    rst_b_n = 1'b1;
    step_b(2'b11, 4'h0, 1'b0);
    step_b(2'b11, 4'h0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      step_b(2'b10, 4'h5, 1'b1);
      step_b(2'b10, 4'h5, 1'b0);
      step_b(2'b10, 4'h5, 1'b0);
      step_b(2'b01, 4'hC, 1'b0);
      step_b(2'b01, 4'hC, 1'b0);
      step_b(2'b01, 4'hC, 1'b0);
    end

    // Random digits and en on both instances.
    @(posedge clk); #1;
    rnd_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus_a.en     = 1'($urandom_range(0, 1));
      bus_a.digit0 = 4'($urandom_range(0, 15));
      bus_a.digit1 = 4'($urandom_range(0, 15));
      bus_b.en     = 1'($urandom_range(0, 1));
      bus_b.digit0 = 4'($urandom_range(0, 15));
      bus_b.digit1 = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    rnd_on = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
